// File: rtl/alu_log_pkg.sv
// Shared types and constants for the ALU result log: entry layout, FSM encoding,
// flag bit positions and the view tags shown on the 7-segment code.
package alu_log_pkg;

  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned RES_W     = 16;
  localparam int unsigned FLG_W     = 4;
  localparam int unsigned CNT_W     = 4;

  localparam int unsigned FLAG_CF = 3;
  localparam int unsigned FLAG_ZF = 2;
  localparam int unsigned FLAG_SF = 1;
  localparam int unsigned FLAG_VF = 0;

  localparam logic [3:0] TAG_LIVE = 4'h0;
  localparam logic [3:0] TAG_RES  = 4'hA;
  localparam logic [3:0] TAG_FLG  = 4'hF;

  typedef enum logic [1:0] {
    ST_LIVE     = 2'd0,
    ST_VIEW_RES = 2'd1,
    ST_VIEW_FLG = 2'd2
  } state_t;

  typedef struct packed {
    logic [FLG_W-1:0] flags;
    logic [RES_W-1:0] result;
  } entry_t;

endpackage

// File: rtl/log_ram.sv
// DEPTH x entry register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module log_ram
  import alu_log_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  entry_t            i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output entry_t            o_rdata
);

  entry_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_result_log.sv
// Circular log of ALU results/flags with a browse FSM that walks entries by age,
// newest first, alternating result and flag views on the LED/7-segment outputs.
module alu_result_log
  import alu_log_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clock_btn,
  input  logic             reset_btn,
  input  logic [RES_W-1:0] alu_result,
  input  logic [FLG_W-1:0] alu_flags,
  input  logic             commit,
  input  logic             browse,
  input  logic             clear,
  output logic [15:0]      log_leds,
  output logic [7:0]       log_number,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  state_t             r_state, w_state_n;
  logic [PTR_W-1:0]   r_age, w_age_n;
  logic [PTR_W-1:0]   r_wr_ptr, w_wr_ptr_n;
  logic [CNT_W-1:0]   r_count, w_count_n;
  logic               w_we;
  logic [PTR_W-1:0]   w_raddr;
  logic [CNT_W-1:0]   w_age_inc;
  entry_t             w_wdata;
  entry_t             w_rdata;

  // Age k lives at wr_ptr-1-k; in LIVE age is 0, so this also yields the newest entry.
  assign w_raddr   = PTR_W'(r_wr_ptr - PTR_W'(1) - r_age);
  assign w_age_inc = CNT_W'(r_age) + CNT_W'(1);
  assign w_wdata   = '{flags: alu_flags, result: alu_result};

  // A write on an edge where reset is also high must not land.
  assign w_we = commit && !clear && !reset_btn;

  log_ram #(.DEPTH(DEPTH)) u_ram (
    .i_clk   (clock_btn),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock_btn or posedge reset_btn) begin
    if (reset_btn) begin
      r_state  <= ST_LIVE;
      r_age    <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_n;
      r_age    <= w_age_n;
      r_wr_ptr <= w_wr_ptr_n;
      r_count  <= w_count_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_age_n    = r_age;
    w_wr_ptr_n = r_wr_ptr;
    w_count_n  = r_count;
    if (clear) begin
      w_state_n  = ST_LIVE;
      w_age_n    = '0;
      w_wr_ptr_n = '0;
      w_count_n  = '0;
    end else begin
      if (commit) begin
        w_wr_ptr_n = PTR_W'(r_wr_ptr + PTR_W'(1));
        if (r_count != CNT_W'(DEPTH)) w_count_n = CNT_W'(r_count + CNT_W'(1));
      end
      // Age is held numerically across a commit, so the view follows the shifted entry.
      case (r_state)
        ST_LIVE: begin
          if (browse && (r_count != '0)) begin
            w_state_n = ST_VIEW_RES;
            w_age_n   = '0;
          end
        end
        ST_VIEW_RES: begin
          if (browse) begin
            w_state_n = ST_VIEW_FLG;
          end else begin
            w_state_n = ST_LIVE;
            w_age_n   = '0;
          end
        end
        ST_VIEW_FLG: begin
          if (browse) begin
            w_state_n = ST_VIEW_RES;
            w_age_n   = (w_age_inc >= r_count) ? '0 : PTR_W'(w_age_inc);
          end else begin
            w_state_n = ST_LIVE;
            w_age_n   = '0;
          end
        end
        default: begin
          w_state_n = ST_LIVE;
          w_age_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    log_leds   = '0;
    log_number = {r_count, TAG_LIVE};
    case (r_state)
      ST_LIVE: begin
        if (r_count != '0) log_leds = w_rdata.result;
      end
      ST_VIEW_RES: begin
        log_leds   = w_rdata.result;
        log_number = {4'(r_age), TAG_RES};
      end
      ST_VIEW_FLG: begin
        log_leds   = {12'b0, w_rdata.flags[FLAG_CF], w_rdata.flags[FLAG_ZF],
                      w_rdata.flags[FLAG_SF], w_rdata.flags[FLAG_VF]};
        log_number = {4'(r_age), TAG_FLG};
      end
      default: begin
        log_leds   = '0;
        log_number = '0;
      end
    endcase
  end

  assign count = r_count;
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: doc/alu_result_log.md
ALU_RESULT_LOG -- requirements
Module: alu_result_log

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of logged entries (power of two).
REQ-002 SHALL have port clock_btn  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_btn  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port alu_result  input  16  result produced by the ALU stage.
REQ-005 SHALL have port alu_flags  input  4  {cf, zf, sf, vf} produced by the ALU stage.
REQ-006 SHALL have port commit  input  1  level; when high at an edge, it logs the current alu_result/alu_flags.
REQ-007 SHALL have port browse  input  1  level; when high at an edge, it steps the browse view.
REQ-008 SHALL have port clear  input  1  level; when high at an edge, it empties the log.
REQ-009 SHALL have port log_leds  output  16  displayed value (result or zero-extended flags).
REQ-010 SHALL have port log_number  output  8  7-segment code: [7:4] entry age, [3:0] view tag.
REQ-011 SHALL have port count  output  4  number of valid entries, 0..DEPTH.
REQ-012 SHALL have ports full and empty  output  1 each  meaning count==DEPTH and count==0.

Function
REQ-013 SHALL store each entry as 20 bits {flags[3:0], result[15:0]} in a circular buffer with a write pointer taken modulo DEPTH.
REQ-014 SHALL, on commit, write the entry at wr_ptr, advance wr_ptr, and increment count if not full.
REQ-015 SHALL, on commit while full, overwrite the oldest entry while count stays at DEPTH; no entry is ever lost except the oldest.
REQ-016 SHALL give clear priority over commit at the same edge: count=0, wr_ptr=0, commit ignored.
REQ-017 SHALL address entries by age: age 0 is the newest, and age k is stored at (wr_ptr-1-k) mod DEPTH.
REQ-018 SHALL implement FSM states LIVE, VIEW_RES, VIEW_FLG.
REQ-019 SHALL, in LIVE, output log_leds = newest result, or 0 if empty, and log_number = {count, 4'h0}.
REQ-020 SHALL move LIVE to VIEW_RES with age=0 on browse=1 and count>0; with browse=1 and count==0 it stays in LIVE.
REQ-021 SHALL, in VIEW_RES, output log_leds = result[age] and log_number = {age, 4'hA}.
REQ-022 SHALL, in VIEW_FLG, output log_leds = {12'b0, flags[age]} and log_number = {age, 4'hF}.
REQ-023 SHALL, on browse=1, move VIEW_RES to VIEW_FLG with age unchanged.
REQ-024 SHALL, on browse=1, move VIEW_FLG to VIEW_RES with age+1, wrapping to 0 when age+1 >= count.
REQ-025 SHALL return from any VIEW state to LIVE on browse=0; age resets to 0.
REQ-026 SHALL return to LIVE on clear from any state, regardless of browse.
REQ-027 SHALL handle commit during a VIEW state as follows: the write occurs, age stays numerically unchanged, and the view then refers to the shifted entry.
REQ-028 SHALL produce log_leds/log_number combinationally from registered state and buffer; new data is visible immediately after the edge that wrote it.

Reset
REQ-029 SHALL, on reset_btn high, immediately set state=LIVE, wr_ptr=0, count=0, age=0, so outputs are log_leds=0, log_number=0, empty=1, full=0.
REQ-030 SHALL NOT reset buffer contents; unused contents are never displayed while count=0.
REQ-031 SHALL let reset asserted mid-browse or mid-commit win unconditionally; no write completes on that edge.

Structure
REQ-032 SHALL place in package alu_log_pkg: DEPTH default, FSM state encoding, flag bit indices (CF=3, ZF=2, SF=1, VF=0), view tags 4'h0/4'hA/4'hF.
REQ-033 SHALL use one sub-module log_ram: a DEPTH x 20 register array with 1 write port and 1 async read port, no reset.

Verification
REQ-034 SHALL cover: reset, then commit result=16'h0003 flags=4'b0000 -> count=1, LIVE log_leds=16'h0003, log_number=8'h10.
REQ-035 SHALL cover: commit 9 entries with results 1..9 -> count=8, full=1; browse at age 7 shows 16'h0002 (the value 1 is overwritten).
REQ-036 SHALL cover: 3 entries, browse 6 edges -> sequence VIEW_RES a0, VIEW_FLG a0, a1, a1, a2, a2; 7th edge wraps to VIEW_RES age 0 (log_number=8'h0A).
REQ-037 SHALL cover: commit of 16'h8000+16'h8000 with flags 4'b1101 logged, browsed to VIEW_FLG -> log_leds=16'h000D, log_number=8'h0F.
REQ-038 SHALL cover: clear and commit at the same edge while browsing -> count=0, state LIVE, log_leds=0.
REQ-039 SHALL cover: reset_btn pulse between clock edges during VIEW_FLG -> outputs zero immediately; next browse with empty log stays in LIVE.
